// File: rtl/ghostbus_top_if.sv
// gb_* host bus bundle: word address, write data/strobe, read strobe and registered read data.
interface ghostbus_top_if;
  logic [23:0] gb_addr;
  logic [31:0] gb_wdata;
  logic        gb_wen;
  logic        gb_rstb;
  logic [31:0] gb_rdata;

  modport master (output gb_addr, gb_wdata, gb_wen, gb_rstb, input gb_rdata);
  modport slave  (input gb_addr, gb_wdata, gb_wen, gb_rstb, output gb_rdata);
endinterface

// File: rtl/ghostbus_top.sv
// ghostbus root block: top CSRs, per-copy foo CSR/RAM pairs and optional baz CSR/RAM,
// with a two-stage registered read path on the gb_* bus.
module ghostbus_top #(
  parameter int FOO_COPIES = 4,
  parameter int TOP_BAZ    = 1
) (
  input  logic          gb_clk,
  input  logic          gb_rst_n,
  ghostbus_top_if.slave gb
);

  localparam bit         HAS_BAZ = (TOP_BAZ != 0);
  localparam logic [3:0] BAZ_RST = 4'(TOP_BAZ);

  logic [7:0]  top_reg_q, top_reg_d;
  logic [3:0]  top_baz_q, top_baz_d;
  logic [3:0]  top_foo_q [4];
  logic [3:0]  top_foo_d [4];
  logic [7:0]  baz_ram_q [8];
  logic [7:0]  baz_ram_d [8];
  logic [7:0]  foo_ram_q [4][8];
  logic [7:0]  foo_ram_d [4][8];

  logic [31:0] rd1_data_q, rd1_data_d;
  logic        rd1_vld_q, rd1_vld_d;
  logic [31:0] rd2_data_q, rd2_data_d;
  logic        rd2_vld_q, rd2_vld_d;
  logic [31:0] rdata_q, rdata_d;

  logic        sel_top, sel_baz, sel_foo, sel_bram, sel_fram;
  logic [31:0] rd_mux;
  logic        wdata_unused;

  assign wdata_unused = ^gb.gb_wdata[31:8];
  assign gb.gb_rdata  = rdata_q;

  // Address decode; foo slots beyond FOO_COPIES and the baz region when absent decode as unmapped.
  always_comb begin
    sel_top  = (gb.gb_addr == 24'h000000);
    sel_baz  = HAS_BAZ && (gb.gb_addr == 24'h000001);
    sel_foo  = (gb.gb_addr[23:2] == 22'h1) && (32'(gb.gb_addr[1:0]) < FOO_COPIES);
    sel_bram = HAS_BAZ && (gb.gb_addr[23:3] == 21'h1);
    sel_fram = (gb.gb_addr[23:5] == 19'h1) && (32'(gb.gb_addr[4:3]) < FOO_COPIES);
  end

  always_comb begin
    rd_mux = '0;
    if (sel_top)  rd_mux = {24'b0, top_reg_q};
    if (sel_baz)  rd_mux = {28'b0, top_baz_q};
    if (sel_foo)  rd_mux = {28'b0, top_foo_q[gb.gb_addr[1:0]]};
    if (sel_bram) rd_mux = {24'b0, baz_ram_q[gb.gb_addr[2:0]]};
    if (sel_fram) rd_mux = {24'b0, foo_ram_q[gb.gb_addr[4:3]][gb.gb_addr[2:0]]};
  end

  // RAMs have no reset, so their writes are explicitly blocked while gb_rst_n is low.
  always_comb begin
    top_reg_d = top_reg_q;
    top_baz_d = top_baz_q;
    top_foo_d = top_foo_q;
    baz_ram_d = baz_ram_q;
    foo_ram_d = foo_ram_q;
    if (gb.gb_wen) begin
      if (sel_top)              top_reg_d = gb.gb_wdata[7:0];
      if (sel_baz)              top_baz_d = gb.gb_wdata[3:0];
      if (sel_foo)              top_foo_d[gb.gb_addr[1:0]] = gb.gb_wdata[3:0];
      if (sel_bram && gb_rst_n) baz_ram_d[gb.gb_addr[2:0]] = gb.gb_wdata[7:0];
      if (sel_fram && gb_rst_n) foo_ram_d[gb.gb_addr[4:3]][gb.gb_addr[2:0]] = gb.gb_wdata[7:0];
    end
  end

  // Read value is captured at the strobe edge (so a same-cycle write is not seen) and
  // travels two more stages; gb_rdata only changes when a result lands.
  always_comb begin
    rd1_vld_d  = gb.gb_rstb;
    rd1_data_d = gb.gb_rstb ? rd_mux : rd1_data_q;
    rd2_vld_d  = rd1_vld_q;
    rd2_data_d = rd1_data_q;
    rdata_d    = rd2_vld_q ? rd2_data_q : rdata_q;
  end

  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      top_reg_q  <= 8'h00;
      top_baz_q  <= BAZ_RST;
      for (int i = 0; i < 4; i++) top_foo_q[i] <= 4'(i);
      rd1_data_q <= '0;
      rd1_vld_q  <= 1'b0;
      rd2_data_q <= '0;
      rd2_vld_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      top_reg_q  <= top_reg_d;
      top_baz_q  <= top_baz_d;
      top_foo_q  <= top_foo_d;
      rd1_data_q <= rd1_data_d;
      rd1_vld_q  <= rd1_vld_d;
      rd2_data_q <= rd2_data_d;
      rd2_vld_q  <= rd2_vld_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge gb_clk) begin
    baz_ram_q <= baz_ram_d;
    foo_ram_q <= foo_ram_d;
  end

endmodule

// File: tb/tb_ghostbus_top.sv
// Self-checking bench for ghostbus_top: vector table for CSR/unmapped behaviour, loops for the
// RAMs, hand sequences for latency, same-cycle write+read and mid-read reset.
module tb_ghostbus_top;

  logic gb_clk   = 1'b0;
  logic gb_rst_n = 1'b0;

  ghostbus_top_if bus ();

  ghostbus_top #(.FOO_COPIES(4), .TOP_BAZ(1)) dut (
    .gb_clk   (gb_clk),
    .gb_rst_n (gb_rst_n),
    .gb       (bus)
  );

  always #5 gb_clk = ~gb_clk;

  typedef struct {
    logic        wen;
    logic        rstb;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [23:0] addr_q [$];
  logic        p1 = 1'b0;
  logic        p2 = 1'b0;
  logic        fire;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Drives one bus cycle (caller sits at a negedge) and returns at the following negedge.
  task automatic applyStimulus(input logic wen, input logic rstb, input logic [23:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp);
    bus.gb_wen   = wen;
    bus.gb_rstb  = rstb;
    bus.gb_addr  = addr;
    bus.gb_wdata = wdata;
    if (rstb) begin
      exp_q.push_back(exp);
      addr_q.push_back(addr);
    end
    @(negedge gb_clk);
    bus.gb_wen  = 1'b0;
    bus.gb_rstb = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.gb_wen  = 1'b0;
    bus.gb_rstb = 1'b0;
    repeat (n) @(negedge gb_clk);
  endtask

  // Scoreboard monitor: a strobe accepted at edge N has its result checked just after edge N+2.
  initial begin
    forever begin
      @(posedge gb_clk);
      fire = p2;
      p2   = p1;
      p1   = bus.gb_rstb && gb_rst_n;
      if (!gb_rst_n) begin
        p1   = 1'b0;
        p2   = 1'b0;
        fire = 1'b0;
      end
      if (fire) begin
        #1;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", bus.gb_rdata, 32'hDEAD_BEEF);
        end else begin
          automatic logic [23:0] a = addr_q.pop_front();
          automatic logic [31:0] e = exp_q.pop_front();
          checkOutput($sformatf("rd@%06h", a), bus.gb_rdata, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t        vecs [$];
  logic [7:0]  foo_base [4];
  logic [31:0] held;

  initial begin
    bus.gb_wen   = 1'b0;
    bus.gb_rstb  = 1'b0;
    bus.gb_addr  = '0;
    bus.gb_wdata = '0;
    foo_base[0] = 8'hD0;
    foo_base[1] = 8'hC8;
    foo_base[2] = 8'hB0;
    foo_base[3] = 8'hA8;

    vecs = '{
      '{1'b0, 1'b1, 24'h000000, 32'h0, 32'h00},
      '{1'b0, 1'b1, 24'h000001, 32'h0, 32'h01},
      '{1'b0, 1'b1, 24'h000004, 32'h0, 32'h00},
      '{1'b0, 1'b1, 24'h000005, 32'h0, 32'h01},
      '{1'b0, 1'b1, 24'h000006, 32'h0, 32'h02},
      '{1'b0, 1'b1, 24'h000007, 32'h0, 32'h03},
      '{1'b0, 1'b1, 24'h000000, 32'h0, 32'h00},
      '{1'b0, 1'b1, 24'h000001, 32'h0, 32'h01},
      '{1'b0, 1'b1, 24'h000007, 32'h0, 32'h03},
      '{1'b1, 1'b0, 24'h000000, 32'h0000_00CC, 32'h0},
      '{1'b1, 1'b0, 24'h000001, 32'h0000_0001, 32'h0},
      '{1'b1, 1'b0, 24'h000004, 32'h0000_0004, 32'h0},
      '{1'b1, 1'b0, 24'h000005, 32'h0000_0005, 32'h0},
      '{1'b1, 1'b0, 24'h000006, 32'h0000_0006, 32'h0},
      '{1'b1, 1'b0, 24'h000007, 32'h0000_0007, 32'h0},
      '{1'b0, 1'b1, 24'h000000, 32'h0, 32'hCC},
      '{1'b0, 1'b1, 24'h000001, 32'h0, 32'h01},
      '{1'b0, 1'b1, 24'h000004, 32'h0, 32'h04},
      '{1'b0, 1'b1, 24'h000005, 32'h0, 32'h05},
      '{1'b0, 1'b1, 24'h000006, 32'h0, 32'h06},
      '{1'b0, 1'b1, 24'h000007, 32'h0, 32'h07},
      '{1'b1, 1'b0, 24'h000001, 32'hFFFF_FFFF, 32'h0},
      '{1'b0, 1'b1, 24'h000001, 32'h0, 32'h0F},
      '{1'b0, 1'b1, 24'h000002, 32'h0, 32'h00},
      '{1'b0, 1'b1, 24'h000010, 32'h0, 32'h00},
      '{1'b0, 1'b1, 24'h000040, 32'h0, 32'h00},
      '{1'b0, 1'b1, 24'hFFFFFF, 32'h0, 32'h00},
      '{1'b1, 1'b0, 24'h000002, 32'h5A5A_5A5A, 32'h0},
      '{1'b1, 1'b0, 24'h000003, 32'h5A5A_5A5A, 32'h0},
      '{1'b1, 1'b0, 24'h000010, 32'h5A5A_5A5A, 32'h0},
      '{1'b1, 1'b0, 24'h000040, 32'h5A5A_5A5A, 32'h0},
      '{1'b1, 1'b0, 24'hFFFFFF, 32'h5A5A_5A5A, 32'h0},
      '{1'b1, 1'b0, 24'h000100, 32'h5A5A_5A5A, 32'h0},
      '{1'b0, 1'b1, 24'h000002, 32'h0, 32'h00},
      '{1'b0, 1'b1, 24'h000000, 32'h0, 32'hCC},
      '{1'b0, 1'b1, 24'h000001, 32'h0, 32'h0F},
      '{1'b0, 1'b1, 24'h000004, 32'h0, 32'h04},
      '{1'b0, 1'b1, 24'h000007, 32'h0, 32'h07}
    };

    repeat (3) @(negedge gb_clk);
    checkOutput("reset_rdata", bus.gb_rdata, 32'h0);
    gb_rst_n = 1'b1;

    // First strobe lands on the first rising edge after release.
    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i].wen, vecs[i].rstb, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    idle(4);

    // RAM fill with junk in the upper bits, then unmapped writes, then pipelined readback.
    for (int j = 0; j < 8; j++)
      applyStimulus(1'b1, 1'b0, 24'h08 + 24'(j), {24'hABCDEF, 8'hE8 + 8'(j)}, 32'h0);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 8; j++)
        applyStimulus(1'b1, 1'b0, 24'h20 + 24'(8 * r + j), {24'h123456, foo_base[r] + 8'(j)}, 32'h0);
    applyStimulus(1'b1, 1'b0, 24'h000040, 32'hFFFF_FF11, 32'h0);
    applyStimulus(1'b1, 1'b0, 24'h000018, 32'hFFFF_FF22, 32'h0);
    applyStimulus(1'b1, 1'b0, 24'h800008, 32'hFFFF_FF33, 32'h0);
    for (int j = 0; j < 8; j++)
      applyStimulus(1'b0, 1'b1, 24'h08 + 24'(j), 32'h0, {24'h0, 8'hE8 + 8'(j)});
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 8; j++)
        applyStimulus(1'b0, 1'b1, 24'h20 + 24'(8 * r + j), 32'h0, {24'h0, foo_base[r] + 8'(j)});
    idle(4);

    // Same-cycle write+read returns the old value; the next read sees the new one.
    applyStimulus(1'b1, 1'b0, 24'h000000, 32'h0000_0011, 32'h0);
    applyStimulus(1'b1, 1'b1, 24'h000000, 32'h0000_0022, 32'h11);
    applyStimulus(1'b0, 1'b1, 24'h000000, 32'h0, 32'h22);
    idle(4);

    // Explicit latency and hold: strobe at edge N, value present after N+2 and kept.
    bus.gb_rstb = 1'b1;
    bus.gb_addr = 24'h000006;
    exp_q.push_back(32'h06);
    addr_q.push_back(24'h000006);
    @(posedge gb_clk);
    @(negedge gb_clk);
    bus.gb_rstb = 1'b0;
    bus.gb_addr = 24'h000000;
    @(posedge gb_clk);
    @(posedge gb_clk);
    #1;
    checkOutput("latency_n2", bus.gb_rdata, 32'h06);
    repeat (3) @(posedge gb_clk);
    #1;
    checkOutput("rdata_held", bus.gb_rdata, 32'h06);

    // Reset in the middle of a read: output clears at once and the read is dropped.
    @(negedge gb_clk);
    bus.gb_rstb = 1'b1;
    bus.gb_addr = 24'h000000;
    @(posedge gb_clk);
    #2;
    gb_rst_n    = 1'b0;
    bus.gb_rstb = 1'b0;
    #1;
    checkOutput("rst_rdata_async", bus.gb_rdata, 32'h0);
    @(negedge gb_clk);
    bus.gb_wen   = 1'b1;
    bus.gb_addr  = 24'h000008;
    bus.gb_wdata = 32'h0000_0055;
    @(negedge gb_clk);
    bus.gb_wen = 1'b0;
    @(negedge gb_clk);
    checkOutput("rst_rdata_hold", bus.gb_rdata, 32'h0);
    gb_rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 24'h000000, 32'h0, 32'h00);
    applyStimulus(1'b0, 1'b1, 24'h000001, 32'h0, 32'h01);
    applyStimulus(1'b0, 1'b1, 24'h000004, 32'h0, 32'h00);
    applyStimulus(1'b0, 1'b1, 24'h000005, 32'h0, 32'h01);
    applyStimulus(1'b0, 1'b1, 24'h000006, 32'h0, 32'h02);
    applyStimulus(1'b0, 1'b1, 24'h000007, 32'h0, 32'h03);
    applyStimulus(1'b0, 1'b1, 24'h000008, 32'h0, 32'hE8);
    applyStimulus(1'b0, 1'b1, 24'h000020, 32'h0, 32'hD0);
    applyStimulus(1'b0, 1'b1, 24'h00003F, 32'h0, 32'hAF);
    idle(5);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    held = bus.gb_rdata;
    checkOutput("final_rdata", held, 32'hAF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ghostbus_top.md
# ghostbus_top

Top-level register/RAM block on the gb_* host bus: a small set of CSRs plus several 8-entry byte RAMs, addressed through a 24-bit word address with a registered 32-bit read path. It is the root of the bus hierarchy and contains FOO_COPIES "foo" sub-blocks (one CSR and one RAM each) and an optional "baz" sub-block. All storage is read/write; reads are zero-extended to 32 bits.

## Interface
- FOO_COPIES, 4: number of foo sub-blocks; legal range 1..4.
- TOP_BAZ, 1: nonzero instantiates baz (top_baz CSR and baz_ram); 0 removes them. Also the top_baz reset value (TOP_BAZ[3:0]).

- gb_clk  input  1  sole clock; all logic on rising edge.
- gb_rst_n  input  1  asynchronous, active-low reset of CSRs and read pipeline.
- gb_addr  input  24  word address, fully decoded.
- gb_wdata  input  32  write data.
- gb_wen  input  1  write strobe, one write per cycle high.
- gb_rstb  input  1  read strobe, one read per cycle high.
- gb_rdata  output  32  read data, registered.

## Operation
- Memory map (all other addresses: reads return 0, writes ignored):
  - 0x000000 top_reg: 8-bit CSR, reset 0x00.
  - 0x000001 top_baz: 4-bit CSR, reset TOP_BAZ[3:0]; absent if TOP_BAZ==0.
  - 0x000004+i top_foo_n[i], i<FOO_COPIES: 4-bit CSR, reset i.
  - 0x000008..0x00000F baz_ram: 8 x 8-bit; absent if TOP_BAZ==0.
  - 0x000020+8*i .. 0x000027+8*i foo_ram[i], i<FOO_COPIES: 8 x 8-bit.
- Write: gb_wen high at a rising edge stores gb_wdata[W-1:0] of the target (W = CSR/RAM width); upper bits discarded.
- Read: gb_rstb high at a rising edge captures the addressed value; value appears on gb_rdata zero-extended.
- RAMs: synchronous read; contents power up to 0x00 and are NOT cleared by gb_rst_n.
- Reset (gb_rst_n low, asynchronous): CSRs to reset values, gb_rdata to 0, in-flight read cancelled. Writes/read strobes ignored while reset asserted.

## Timing
- Write latency: stored at the edge where gb_wen is sampled high; readable by a strobe on the next cycle.
- Read latency: strobe sampled at edge N; gb_rdata valid after edge N+2, held unchanged until the next read result lands. Bus masters sample at N+3 or later.
- Back-to-back strobes on consecutive cycles are pipelined: one result per cycle, in order.
- gb_wen and gb_rstb high in the same cycle to the same address: read returns the old value, write takes effect.
- gb_rstb with no mapped target: result 0x00000000 after the same 2-cycle latency.
- Reset release: first strobe accepted at the first rising edge with gb_rst_n high.

## Test plan
- After reset, read 0x00, 0x01, 0x04..0x07 -> 0x00, 0x01, 0x00, 0x01, 0x02, 0x03; reading every mapped address twice -> identical results.
- Write 0xCC to 0x00, 0x01 to 0x01, 0x04..0x07 to 0x04..0x07 -> read back the same values; write 0xFFFFFFFF to 0x01 -> reads 0x0000000F.
- Write 0xE8..0xEF to 0x08..0x0F and D0..D7/C8..CF/B0..B7/A8..AF to foo_ram 0x20..0x3F -> each address reads back its written byte, no aliasing between RAMs.
- Read unmapped 0x02, 0x10, 0x40, 0xFFFFFF -> 0; writes there do not disturb any mapped location.
- Strobe read at edge N -> gb_rdata correct at N+2 and held; simultaneous write+read to 0x00 -> old value returned, new value on next read.
- Assert gb_rst_n mid-read -> gb_rdata 0 immediately, CSRs back to reset values, RAM contents retained.
